// File: rtl/key_entry_controller_if.sv
// Word hand-off bundle between the key entry controller and the game logic.
// The producer drives the live buffer contents and length plus the offer
// strobe; the consumer answers with word_ready.
interface key_entry_controller_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
);
    logic [5*MAX_LEN-1:0] cur_word;
    logic [LEN_W-1:0]     cur_len;
    logic                 word_valid;
    logic                 word_ready;

    modport master (
        output cur_word,
        output cur_len,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  cur_word,
        input  cur_len,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/key_entry_controller.sv
// Key entry controller for the typing game.
// Latches each new make code onto the decoder port, samples the decoded
// letter one cycle later and edits a small word buffer (append, backspace,
// enter). A finished word is held on the bus with word_valid until the
// consumer takes it. Keys arriving while busy are dropped, never queued.
module key_entry_controller #(
    parameter int         MAX_LEN    = 8,
    parameter int         LEN_W      = 4,
    parameter logic [8:0] CODE_ENTER = 9'h5A,
    parameter logic [8:0] CODE_BKSP  = 9'h66
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_valid,
    input  logic [8:0]             last_change,
    output logic [8:0]             dec_code,
    input  logic [4:0]             dec_alpha,
    output logic                   overflow,
    output logic                   key_drop,
    key_entry_controller_if.master word_if
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        OFFER
    } state_t;

    state_t           state_reg;
    logic [4:0]       slot_reg [MAX_LEN];
    logic [LEN_W-1:0] len_reg;
    logic [8:0]       dec_code_reg;
    logic             valid_reg;
    logic             overflow_reg;
    logic             key_drop_reg;

    logic             is_letter;
    logic             len_full;
    logic             len_empty;
    logic [LEN_W-1:0] len_dec;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] bk_idx;

    // Decoder result classification and slot addressing for append/backspace.
    assign is_letter = (dec_alpha >= 5'd1) && (dec_alpha <= 5'd26);
    assign len_full  = (len_reg == MAX_LEN_L);
    assign len_empty = (len_reg == '0);
    assign len_dec   = len_reg - 1'b1;
    assign wr_idx    = len_reg[IDX_W-1:0];
    assign bk_idx    = len_dec[IDX_W-1:0];

    // Flatten the slot array onto the bus: slot i sits at bits [5i+4:5i].
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_pack
            assign word_if.cur_word[5*gi +: 5] = slot_reg[gi];
        end
    endgenerate

    assign word_if.cur_len    = len_reg;
    assign word_if.word_valid = valid_reg;
    assign dec_code           = dec_code_reg;
    assign overflow           = overflow_reg;
    assign key_drop           = key_drop_reg;

    // Control FSM: capture key, act on decoded result, hold word until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            dec_code_reg <= '0;
            len_reg      <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            key_drop_reg <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            overflow_reg <= 1'b0;
            key_drop_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (key_valid) begin
                        dec_code_reg <= last_change;
                        state_reg    <= DECODE;
                    end
                end
                DECODE: begin
                    key_drop_reg <= key_valid;
                    state_reg    <= IDLE;
                    if (dec_code_reg == CODE_ENTER) begin
                        if (!len_empty) begin
                            state_reg <= OFFER;
                            valid_reg <= 1'b1;
                        end
                    end else if (dec_code_reg == CODE_BKSP) begin
                        if (!len_empty) begin
                            slot_reg[bk_idx] <= '0;
                            len_reg          <= len_dec;
                        end
                    end else if (is_letter) begin
                        if (!len_full) begin
                            slot_reg[wr_idx] <= dec_alpha;
                            len_reg          <= len_reg + 1'b1;
                        end else begin
                            overflow_reg <= 1'b1;
                        end
                    end
                end
                OFFER: begin
                    key_drop_reg <= key_valid;
                    if (word_if.word_ready) begin
                        valid_reg <= 1'b0;
                        len_reg   <= '0;
                        state_reg <= IDLE;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            slot_reg[i] <= '0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_entry_controller.sv
// Testbench for key_entry_controller: directed scenarios followed by random
// key streams, compared against a queue-based model of the word buffer.
module tb_key_entry_controller;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam logic [8:0] K_ENTER = 9'h5A;
    localparam logic [8:0] K_BKSP  = 9'h66;
    localparam logic [8:0] K_A = 9'h1C;
    localparam logic [8:0] K_B = 9'h32;
    localparam logic [8:0] K_C = 9'h21;
    localparam logic [8:0] K_H = 9'h33;
    localparam logic [8:0] K_I = 9'h43;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [8:0] last_change = '0;
    logic [8:0] dec_code;
    logic [4:0] dec_alpha;
    logic       overflow;
    logic       key_drop;

    key_entry_controller_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) word_if ();

    key_entry_controller #(
        .MAX_LEN   (MAX_LEN),
        .LEN_W     (LEN_W),
        .CODE_ENTER(K_ENTER),
        .CODE_BKSP (K_BKSP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .last_change(last_change),
        .dec_code   (dec_code),
        .dec_alpha  (dec_alpha),
        .overflow   (overflow),
        .key_drop   (key_drop),
        .word_if    (word_if)
    );

    always #5 clk = ~clk;

    // PS/2 set-2 make codes for A..Z.
    logic [8:0] letter_codes [26] = '{
        9'h1C, 9'h32, 9'h21, 9'h23, 9'h24, 9'h2B, 9'h34, 9'h33, 9'h43,
        9'h3B, 9'h42, 9'h4B, 9'h3A, 9'h31, 9'h44, 9'h4D, 9'h15, 9'h2D,
        9'h1B, 9'h2C, 9'h3C, 9'h2A, 9'h1D, 9'h22, 9'h35, 9'h1A
    };
    logic [8:0] other_codes [4] = '{9'h16, 9'h29, 9'h76, 9'h1F0};

    function automatic logic [4:0] decode(input logic [8:0] c);
        for (int i = 0; i < 26; i++) begin
            if (letter_codes[i] == c) return 5'(i + 1);
        end
        return 5'd27;
    endfunction

    // Combinational letter decoder seen by the DUT.
    always_comb dec_alpha = decode(dec_code);

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the word is simply a list of letter indices.
    int unsigned q[$];
    bit          offering = 1'b0;

    function automatic logic [39:0] model_word();
        logic [39:0] w;
        w = '0;
        for (int i = 0; i < q.size(); i++) w[5*i +: 5] = q[i][4:0];
        return w;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One key press (optionally followed by a second key on the very next cycle).
    task automatic press(input logic [8:0] code, input bit b2b, input logic [8:0] code2);
        bit         exp_ovf;
        logic [4:0] a;
        exp_ovf = 1'b0;
        @(negedge clk);
        key_valid   = 1'b1;
        last_change = code;
        @(negedge clk);
        if (b2b) last_change = code2;
        else     key_valid   = 1'b0;
        check("dec_code", 64'(dec_code), 64'(code));
        if (code == K_ENTER) begin
            if (q.size() > 0) offering = 1'b1;
        end else if (code == K_BKSP) begin
            if (q.size() > 0) void'(q.pop_back());
        end else begin
            a = decode(code);
            if (a >= 5'd1 && a <= 5'd26) begin
                if (q.size() < MAX_LEN) q.push_back(32'(a));
                else exp_ovf = 1'b1;
            end
        end
        @(negedge clk);
        key_valid = 1'b0;
        check("cur_len",    64'(word_if.cur_len),    64'(q.size()));
        check("cur_word",   64'(word_if.cur_word),   64'(model_word()));
        check("word_valid", 64'(word_if.word_valid), 64'(offering));
        check("overflow",   64'(overflow),           64'(exp_ovf));
        check("key_drop",   64'(key_drop),           64'(b2b));
        check("dec_hold",   64'(dec_code),           64'(code));
        $display("key %03h b2b=%0d -> len=%0d word=%010h valid=%0d ovf=%0d drop=%0d",
                 code, b2b, word_if.cur_len, word_if.cur_word, word_if.word_valid, overflow, key_drop);
    endtask

    // Hold the offered word for `stall` cycles, then accept it.
    task automatic accept(input int stall, input int drop_at, input bit drop_on_accept);
        logic [39:0] w;
        int          n;
        w = model_word();
        n = q.size();
        for (int k = 0; k < stall; k++) begin
            word_if.word_ready = 1'b0;
            key_valid   = (k == drop_at);
            last_change = K_A;
            @(negedge clk);
            key_valid = 1'b0;
            check("hold_valid", 64'(word_if.word_valid), 64'd1);
            check("hold_word",  64'(word_if.cur_word),   64'(w));
            check("hold_len",   64'(word_if.cur_len),    64'(n));
            check("hold_drop",  64'(key_drop),           64'(k == drop_at));
        end
        word_if.word_ready = 1'b1;
        key_valid   = drop_on_accept;
        last_change = K_A;
        @(negedge clk);
        word_if.word_ready = 1'b0;
        key_valid = 1'b0;
        check("acc_valid", 64'(word_if.word_valid), 64'd0);
        check("acc_len",   64'(word_if.cur_len),    64'd0);
        check("acc_word",  64'(word_if.cur_word),   64'd0);
        check("acc_drop",  64'(key_drop),           64'(drop_on_accept));
        $display("accept word=%010h len=%0d stall=%0d drop_at=%0d drop_on_acc=%0d",
                 w, n, stall, drop_at, drop_on_accept);
        q.delete();
        offering = 1'b0;
    endtask

    initial begin
        int         r;
        int         st;
        logic [8:0] c;
        word_if.word_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_len",   64'(word_if.cur_len),    64'd0);
        check("rst_word",  64'(word_if.cur_word),   64'd0);
        check("rst_valid", 64'(word_if.word_valid), 64'd0);
        check("rst_dec",   64'(dec_code),           64'd0);
        check("rst_ovf",   64'(overflow),           64'd0);
        check("rst_drop",  64'(key_drop),           64'd0);

        // H, I, enter, immediate accept.
        press(K_H, 0, 0);
        press(K_I, 0, 0);
        press(K_ENTER, 0, 0);
        check("hi_word", 64'(word_if.cur_word), 64'h128);
        accept(0, -1, 0);

        // Editing, then backspace/enter on an empty buffer.
        press(K_A, 0, 0);
        press(K_B, 0, 0);
        press(K_BKSP, 0, 0);
        press(K_C, 0, 0);
        press(K_ENTER, 0, 0);
        check("ac_word", 64'(word_if.cur_word), 64'h061);
        accept(0, -1, 0);
        press(K_BKSP, 0, 0);
        press(K_ENTER, 0, 0);

        // Nine letters into an eight-slot buffer.
        for (int i = 0; i < 9; i++) press(letter_codes[i], 0, 0);
        press(K_ENTER, 0, 0);
        // Stalled consumer with a key arriving mid-offer.
        accept(5, 2, 0);

        // Back-to-back A then B: B is dropped.
        press(K_A, 1, K_B);
        check("b2b_len", 64'(word_if.cur_len), 64'd1);
        press(K_ENTER, 0, 0);
        accept(1, -1, 1);

        // Reset in the middle of an offer.
        press(K_A, 0, 0);
        press(K_B, 0, 0);
        press(K_C, 0, 0);
        press(K_ENTER, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        offering = 1'b0;
        check("mid_rst_valid", 64'(word_if.word_valid), 64'd0);
        check("mid_rst_len",   64'(word_if.cur_len),    64'd0);
        check("mid_rst_word",  64'(word_if.cur_word),   64'd0);
        check("mid_rst_dec",   64'(dec_code),           64'd0);
        $display("reset during offer");
        press(K_A, 0, 0);

        // Random key stream.
        for (int it = 0; it < 400; it++) begin
            if (offering) begin
                st = $urandom_range(0, 4);
                r  = $urandom_range(0, 5);
                accept(st, (r < st) ? r : -1, ($urandom_range(0, 3) == 0));
            end else begin
                r = $urandom_range(0, 19);
                if (r == 0)      c = K_ENTER;
                else if (r < 3)  c = K_BKSP;
                else if (r == 3) c = other_codes[$urandom_range(0, 3)];
                else             c = letter_codes[$urandom_range(0, 25)];
                press(c, ($urandom_range(0, 9) == 0), letter_codes[$urandom_range(0, 25)]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
